// File: rtl/vector_sequencer.sv
// vector_sequencer
//   Loadable operand-pair stimulus source. A DEPTH-entry table of (A, B) pairs
//   is played out over a valid/ready handshake, with an optional number of
//   idle cycles after each accepted vector. Modes: single pass, continuous
//   loop, or pseudo-random pairs taken from a 16-bit Fibonacci LFSR.
//
//   Ports
//     clk, rst_n              clock, asynchronous active-low reset
//     load_en/addr/a/b        table write (only while idle)
//     mode                    00 single, 01 loop, 10 LFSR, 11 as single
//     count                   vectors per pass (clamped to DEPTH for table modes)
//     hold_cycles             idle cycles inserted after each accepted vector
//     start, stop             begin run (idle only) / abort run
//     out_a, out_b, out_valid current operand pair and its valid flag
//     out_ready               consumer accepts the current pair
//     vec_idx                 table index (LFSR: run position mod DEPTH)
//     busy, done              run in progress / one-cycle completion pulse
//   All outputs are registered.
module vector_sequencer #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned HOLD_W = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [WIDTH-1:0]  load_a,
  input  logic [WIDTH-1:0]  load_b,
  input  logic [1:0]        mode,
  input  logic [CW-1:0]     count,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              start,
  input  logic              stop,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW-1:0]     vec_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_HOLD, S_DONE} state_t;
  typedef enum logic [1:0] {M_SINGLE, M_LOOP, M_LFSR} run_mode_t;

  localparam logic [15:0]    LFSR_SEED = 16'hACE1;
  localparam logic [CW-1:0]  DEPTH_C   = CW'(DEPTH);
  localparam logic [AW-1:0]  IDX_MAX   = AW'(DEPTH - 1);

  state_t            state;
  run_mode_t         run_mode;
  run_mode_t         mode_dec;
  logic [WIDTH-1:0]  tab_a [DEPTH];
  logic [WIDTH-1:0]  tab_b [DEPTH];
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     eff_count;
  logic [CW-1:0]     pos;
  logic [CW-1:0]     nxt_pos;
  logic [AW-1:0]     idx;
  logic [AW-1:0]     nxt_idx;
  logic [AW-1:0]     src_idx;
  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] hold_cnt;
  logic [15:0]       lfsr;
  logic [15:0]       nxt_lfsr;
  logic [2*WIDTH-1:0] lf_pair;
  logic              lf_sel;
  logic              last;
  logic [WIDTH-1:0]  vec_a;
  logic [WIDTH-1:0]  vec_b;

  always_comb begin
    mode_dec = M_SINGLE;
    case (mode)
      2'b01:   mode_dec = M_LOOP;
      2'b10:   mode_dec = M_LFSR;
      default: mode_dec = M_SINGLE;
    endcase

    eff_count = count;
    if (mode_dec != M_LFSR && count > DEPTH_C)
      eff_count = DEPTH_C;

    last     = (pos == cnt_r - CW'(1));
    nxt_lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

    // pos tracks run position against count; idx wraps at DEPTH so that
    // LFSR runs longer than the table still report position mod DEPTH.
    // Only loop mode ever advances past the last vector.
    if (last) begin
      nxt_pos = '0;
      nxt_idx = '0;
    end else begin
      nxt_pos = pos + CW'(1);
      nxt_idx = (idx == IDX_MAX) ? '0 : idx + AW'(1);
    end

    // Source of the vector about to be presented: vector 0 when starting,
    // the already-advanced vector when leaving HOLD, the next one otherwise.
    case (state)
      S_IDLE: begin
        src_idx = '0;
        lf_pair = LFSR_SEED[2*WIDTH-1:0];
        lf_sel  = (mode_dec == M_LFSR);
      end
      S_HOLD: begin
        src_idx = idx;
        lf_pair = lfsr[2*WIDTH-1:0];
        lf_sel  = (run_mode == M_LFSR);
      end
      default: begin
        src_idx = nxt_idx;
        lf_pair = nxt_lfsr[2*WIDTH-1:0];
        lf_sel  = (run_mode == M_LFSR);
      end
    endcase

    vec_a = lf_sel ? lf_pair[2*WIDTH-1:WIDTH] : tab_a[src_idx];
    vec_b = lf_sel ? lf_pair[WIDTH-1:0]       : tab_b[src_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      run_mode  <= M_SINGLE;
      cnt_r     <= '0;
      hold_r    <= '0;
      hold_cnt  <= '0;
      pos       <= '0;
      idx       <= '0;
      lfsr      <= LFSR_SEED;
      out_a     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
      vec_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tab_a[i] <= '0;
        tab_b[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_en && 32'(load_addr) < DEPTH) begin
            tab_a[load_addr] <= load_a;
            tab_b[load_addr] <= load_b;
          end
          if (start && eff_count != '0) begin
            run_mode  <= mode_dec;
            cnt_r     <= eff_count;
            hold_r    <= hold_cycles;
            pos       <= '0;
            idx       <= '0;
            if (mode_dec == M_LFSR)
              lfsr <= LFSR_SEED;
            out_a     <= vec_a;
            out_b     <= vec_b;
            out_valid <= 1'b1;
            vec_idx   <= '0;
            busy      <= 1'b1;
            state     <= S_PRESENT;
          end
        end

        S_PRESENT: begin
          if (stop) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (out_ready) begin
            if (last && run_mode != M_LOOP) begin
              state     <= S_DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              pos  <= nxt_pos;
              idx  <= nxt_idx;
              lfsr <= nxt_lfsr;
              if (hold_r != '0) begin
                state     <= S_HOLD;
                hold_cnt  <= hold_r;
                out_valid <= 1'b0;
              end else begin
                out_a   <= vec_a;
                out_b   <= vec_b;
                vec_idx <= nxt_idx;
              end
            end
          end
        end

        S_HOLD: begin
          if (stop) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (hold_cnt == HOLD_W'(1)) begin
            state     <= S_PRESENT;
            out_a     <= vec_a;
            out_b     <= vec_b;
            out_valid <= 1'b1;
            vec_idx   <= idx;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_sequencer.sv
module tb_vector_sequencer;

  localparam int WIDTH  = 5;
  localparam int DEPTH  = 8;
  localparam int HOLD_W = 8;

  logic              clk;
  logic              rst_n;
  logic              load_en;
  logic [2:0]        load_addr;
  logic [WIDTH-1:0]  load_a;
  logic [WIDTH-1:0]  load_b;
  logic [1:0]        mode;
  logic [3:0]        count;
  logic [HOLD_W-1:0] hold_cycles;
  logic              start;
  logic              stop;
  logic [WIDTH-1:0]  out_a;
  logic [WIDTH-1:0]  out_b;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        vec_idx;
  logic              busy;
  logic              done;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [4:0] ta [4] = '{5'b11001, 5'b11101, 5'b00101, 5'b01111};
  logic [4:0] tb [4] = '{5'b10010, 5'b01100, 5'b10001, 5'b00111};

  vector_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_addr(load_addr), .load_a(load_a), .load_b(load_b),
    .mode(mode), .count(count), .hold_cycles(hold_cycles),
    .start(start), .stop(stop),
    .out_a(out_a), .out_b(out_b), .out_valid(out_valid), .out_ready(out_ready),
    .vec_idx(vec_idx), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [1:0] m, input logic [3:0] c, input logic [7:0] h);
    mode = m; count = c; hold_cycles = h; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({out_a, out_b, out_valid, vec_idx, busy, done} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0000", {out_a, out_b, out_valid, vec_idx, busy, done});
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({out_valid, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b expected 000", {out_valid, busy, done});
    end
  endtask

  task automatic test_single;
    for (int i = 0; i < 4; i++) begin
      load_en = 1'b1; load_addr = 3'(i); load_a = ta[i]; load_b = tb[i];
      tick();
    end
    load_en = 1'b0;
    out_ready = 1'b1;
    start_run(2'b00, 4'd4, 8'd0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({out_valid, busy, done, vec_idx, out_a, out_b} !== {1'b1, 1'b1, 1'b0, 3'(i), ta[i], tb[i]}) begin
        n_fail++;
        $display("FAIL single_vec%0d: got v=%b busy=%b done=%b idx=%0d a=%0d b=%0d expected v=1 busy=1 done=0 idx=%0d a=%0d b=%0d",
                 i, out_valid, busy, done, vec_idx, out_a, out_b, i, ta[i], tb[i]);
      end
      tick();
    end
    n_cmp++;
    if ({done, out_valid, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL single_done: got done/valid/busy=%b expected 101", {done, out_valid, busy});
    end
    tick();
    n_cmp++;
    if ({done, out_valid, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL single_idle: got done/valid/busy=%b expected 000", {done, out_valid, busy});
    end
  endtask

  task automatic test_hold_ready;
    int  k = 0;
    int  gap = 0;
    bit  new_vec = 0;
    bit  done_seen = 0;
    out_ready = 1'b0;
    start_run(2'b00, 4'd4, 8'd3);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && !done_seen; cyc++) begin
      if (done) begin
        done_seen = 1;
      end else if (out_valid) begin
        if (new_vec) begin
          n_cmp++;
          if (gap !== 3) begin
            n_fail++;
            $display("FAIL hold_gap: got %0d invalid cycles expected 3 before vec%0d", gap, k);
          end
          new_vec = 0;
        end
        gap = 0;
        n_cmp++;
        if ({vec_idx, out_a, out_b} !== {3'(k), ta[k], tb[k]}) begin
          n_fail++;
          $display("FAIL hold_stable: got idx=%0d a=%0d b=%0d expected idx=%0d a=%0d b=%0d",
                   vec_idx, out_a, out_b, k, ta[k], tb[k]);
        end
      end else begin
        gap++;
        if (k > 0) begin
          n_cmp++;
          if ({out_a, out_b} !== {ta[k-1], tb[k-1]}) begin
            n_fail++;
            $display("FAIL hold_last: got a=%0d b=%0d expected a=%0d b=%0d", out_a, out_b, ta[k-1], tb[k-1]);
          end
        end
      end
      out_ready = ~out_ready;
      if (!done_seen && out_valid && out_ready) begin
        k++;
        new_vec = 1;
      end
      if (!done_seen) tick();
    end
    n_cmp++;
    if (!done_seen || k !== 4) begin
      n_fail++;
      $display("FAIL hold_complete: got done_seen=%0d accepted=%0d expected 1 and 4", done_seen, k);
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_loop_stop;
    out_ready = 1'b1;
    start_run(2'b01, 4'd2, 8'd0);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if ({out_valid, done, vec_idx, out_a, out_b} !== {1'b1, 1'b0, 3'(i % 2), ta[i%2], tb[i%2]}) begin
        n_fail++;
        $display("FAIL loop_vec%0d: got v=%b done=%b idx=%0d a=%0d b=%0d expected v=1 done=0 idx=%0d",
                 i, out_valid, done, vec_idx, out_a, out_b, i % 2);
      end
      if (i < 5) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++;
    if ({out_valid, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL loop_stop: got valid/busy/done=%b expected 000", {out_valid, busy, done});
    end
    tick();
    n_cmp++;
    if ({out_valid, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL loop_stop_after: got valid/busy/done=%b expected 000", {out_valid, busy, done});
    end
  endtask

  task automatic test_lfsr;
    out_ready = 1'b1;
    start_run(2'b10, 4'd2, 8'd0);
    n_cmp++;
    if ({out_valid, vec_idx, out_a, out_b} !== {1'b1, 3'd0, 5'd7, 5'd1}) begin
      n_fail++;
      $display("FAIL lfsr_vec0: got v=%b idx=%0d a=%0d b=%0d expected v=1 idx=0 a=7 b=1", out_valid, vec_idx, out_a, out_b);
    end
    tick();
    n_cmp++;
    if ({out_valid, vec_idx, out_a, out_b} !== {1'b1, 3'd1, 5'd19, 5'd16}) begin
      n_fail++;
      $display("FAIL lfsr_vec1: got v=%b idx=%0d a=%0d b=%0d expected v=1 idx=1 a=19 b=16", out_valid, vec_idx, out_a, out_b);
    end
    tick();
    n_cmp++;
    if ({done, out_valid, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL lfsr_done: got done/valid/busy=%b expected 101", {done, out_valid, busy});
    end
    tick();
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL lfsr_idle: got done/busy=%b expected 00", {done, busy});
    end
  endtask

  task automatic test_corners;
    int  n = 0;
    bit  done_seen = 0;
    logic [4:0] ea;
    logic [4:0] eb;
    out_ready = 1'b1;
    start_run(2'b00, 4'd0, 8'd0);
    n_cmp++;
    if ({busy, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL count0_ignored: got busy/valid=%b expected 00", {busy, out_valid});
    end

    start_run(2'b00, 4'd15, 8'd0);
    for (int cyc = 0; cyc < 30 && !done_seen; cyc++) begin
      if (done) begin
        done_seen = 1;
      end else begin
        if (out_valid) begin
          ea = (n < 4) ? ta[n] : 5'd0;
          eb = (n < 4) ? tb[n] : 5'd0;
          n_cmp++;
          if ({vec_idx, out_a, out_b} !== {3'(n % 8), ea, eb}) begin
            n_fail++;
            $display("FAIL clamp_vec%0d: got idx=%0d a=%0d b=%0d expected idx=%0d a=%0d b=%0d",
                     n, vec_idx, out_a, out_b, n % 8, ea, eb);
          end
          n++;
        end
        tick();
      end
    end
    n_cmp++;
    if (!done_seen || n !== 8) begin
      n_fail++;
      $display("FAIL clamp_count: got done_seen=%0d vectors=%0d expected 1 and 8", done_seen, n);
    end
    tick();

    out_ready = 1'b0;
    start_run(2'b00, 4'd4, 8'd0);
    load_en = 1'b1; load_addr = 3'd1; load_a = 5'd0; load_b = 5'd0;
    mode = 2'b01; count = 4'd2; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    n_cmp++;
    if ({out_valid, busy, vec_idx, out_a, out_b} !== {1'b1, 1'b1, 3'd0, ta[0], tb[0]}) begin
      n_fail++;
      $display("FAIL busy_start_ignored: got v=%b busy=%b idx=%0d a=%0d b=%0d expected v=1 busy=1 idx=0 a=%0d b=%0d",
               out_valid, busy, vec_idx, out_a, out_b, ta[0], tb[0]);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({out_valid, vec_idx, out_a, out_b} !== {1'b1, 3'(i), ta[i], tb[i]}) begin
        n_fail++;
        $display("FAIL load_during_run_vec%0d: got v=%b idx=%0d a=%0d b=%0d expected v=1 idx=%0d a=%0d b=%0d",
                 i, out_valid, vec_idx, out_a, out_b, i, ta[i], tb[i]);
      end
    end
    tick();
    n_cmp++;
    if ({done, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL busy_start_mode_kept: got done/valid=%b expected 10", {done, out_valid});
    end
    tick();
  endtask

  task automatic test_async_reset;
    out_ready = 1'b1;
    start_run(2'b00, 4'd4, 8'd3);
    tick();
    n_cmp++;
    if ({out_valid, busy, out_a, out_b} !== {1'b0, 1'b1, ta[0], tb[0]}) begin
      n_fail++;
      $display("FAIL hold_entry: got v=%b busy=%b a=%0d b=%0d expected v=0 busy=1 a=%0d b=%0d",
               out_valid, busy, out_a, out_b, ta[0], tb[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_a, out_b, out_valid, vec_idx, busy, done} !== 16'h0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected 0000", {out_a, out_b, out_valid, vec_idx, busy, done});
    end
    tick();
    rst_n = 1'b1;
    start_run(2'b00, 4'd4, 8'd0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({out_valid, vec_idx, out_a, out_b} !== {1'b1, 3'(i), 5'd0, 5'd0}) begin
        n_fail++;
        $display("FAIL cleared_table_vec%0d: got v=%b idx=%0d a=%0d b=%0d expected v=1 idx=%0d a=0 b=0",
                 i, out_valid, vec_idx, out_a, out_b, i);
      end
      tick();
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL cleared_table_done: got done=%b expected 1", done);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_a = '0; load_b = '0;
    mode = '0; count = '0; hold_cycles = '0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_hold_ready();
    test_loop_stop();
    test_lfsr();
    test_corners();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
